// File: rtl/wb_rr_arbiter.sv
// Wishbone pipelined arbiter: NM masters share one slave, selected by
// round-robin or fixed priority, with a per-ownership watchdog.
module wb_rr_arbiter #(
    parameter int NM      = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MODE    = 0,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NM-1:0]          m_cyc_i,
    input  logic [NM-1:0]          m_stb_i,
    input  logic [NM-1:0]          m_we_i,
    input  logic [NM*AW-1:0]       m_adr_i,
    input  logic [NM*DW-1:0]       m_dat_i,
    input  logic [NM*(DW/8)-1:0]   m_sel_i,
    output logic [NM-1:0]          m_ack_o,
    output logic [NM-1:0]          m_err_o,
    output logic [NM-1:0]          m_stall_o,
    output logic [DW-1:0]          m_dat_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    output logic                   s_we_o,
    output logic [AW-1:0]          s_adr_o,
    output logic [DW-1:0]          s_dat_o,
    output logic [(DW/8)-1:0]      s_sel_o,
    input  logic                   s_ack_i,
    input  logic                   s_err_i,
    input  logic                   s_stall_i,
    input  logic [DW-1:0]          s_dat_i,
    output logic [NM-1:0]          grant_o,
    output logic                   timeout_o
);

    localparam int OW = $clog2(NM);
    localparam int SW = DW / 8;
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   last_q, last_d;
    logic [WW-1:0]   wdog_q, wdog_d;

    logic [NM-1:0]   own_oh_s;
    logic            own_cyc_s;
    logic            timeout_s;
    logic            rearb_s;
    logic [NM-1:0]   cand_s;
    logic [OW:0]     pick_s;

    // Returns {found, index}; iterating backwards lets the first hit in search order win.
    function automatic logic [OW:0] pick_winner(input logic [NM-1:0] req,
                                                input logic [OW-1:0] last);
        logic [OW:0]   res;
        logic [OW-1:0] idx;
        res = '0;
        if (MODE == 1) begin
            for (int i = NM - 1; i >= 0; i--) begin
                idx = OW'(i);
                if (req[idx]) begin
                    res = {1'b1, idx};
                end else begin
                    res = res;
                end
            end
        end else begin
            for (int i = NM; i >= 1; i--) begin
                idx = OW'((int'(last) + i) % NM);
                if (req[idx]) begin
                    res = {1'b1, idx};
                end else begin
                    res = res;
                end
            end
        end
        return res;
    endfunction

    assign own_oh_s  = NM'(1) << owner_q;
    assign own_cyc_s = m_cyc_i[owner_q];
    assign timeout_s = (state_q == ST_OWNED) && (TIMEOUT != 0) && (wdog_q == WD_LIMIT);

    // Next-state: hold, or re-arbitrate on release/timeout with the old owner excluded.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        cand_s  = m_cyc_i;
        rearb_s = 1'b0;
        if (state_q == ST_IDLE) begin
            rearb_s = 1'b1;
        end else if (timeout_s || !own_cyc_s) begin
            rearb_s = 1'b1;
            cand_s  = m_cyc_i & ~own_oh_s;
        end else if (s_ack_i || s_err_i) begin
            wdog_d = '0;
        end else if (TIMEOUT != 0) begin
            wdog_d = wdog_q + WW'(1);
        end else begin
            wdog_d = '0;
        end

        pick_s = pick_winner(cand_s, last_q);

        if (rearb_s) begin
            wdog_d = '0;
            if (pick_s[OW]) begin
                state_d = ST_OWNED;
                owner_d = pick_s[OW-1:0];
                last_d  = pick_s[OW-1:0];
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State, owner, last owner and watchdog registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= OW'(NM - 1);
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

    // Slave request mux and per-master response routing from the registered owner.
    always_comb begin
        m_dat_o   = s_dat_i;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        m_ack_o   = '0;
        m_err_o   = '0;
        m_stall_o = '1;
        grant_o   = '0;
        timeout_o = 1'b0;
        if (state_q == ST_OWNED) begin
            grant_o   = own_oh_s;
            timeout_o = timeout_s;
            s_cyc_o   = own_cyc_s & ~timeout_s;
            s_stb_o   = m_stb_i[owner_q] & ~timeout_s;
            s_we_o    = m_we_i[owner_q];
            s_adr_o   = m_adr_i[owner_q*AW +: AW];
            s_dat_o   = m_dat_i[owner_q*DW +: DW];
            s_sel_o   = m_sel_i[owner_q*SW +: SW];
            m_ack_o   = s_ack_i ? own_oh_s : '0;
            m_err_o   = (s_err_i || timeout_s) ? own_oh_s : '0;
            m_stall_o = s_stall_i ? '1 : ~own_oh_s;
        end else begin
            grant_o   = '0;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench: round-robin and fixed-priority arbiters driven by the same
// random Wishbone traffic, checked against an owner/last-owner reference model.
module tb_wb_rr_arbiter;

    localparam int NM   = 4;
    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int SW   = DW / 8;
    localparam int TO   = 4;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NM-1:0]    m_cyc, m_stb, m_we;
    logic [NM*AW-1:0] m_adr;
    logic [NM*DW-1:0] m_dat;
    logic [NM*SW-1:0] m_sel;
    logic             s_ack, s_err, s_stall;
    logic [DW-1:0]    s_dat;

    logic [NM-1:0] ack_a [2];
    logic [NM-1:0] err_a [2];
    logic [NM-1:0] stall_a [2];
    logic [NM-1:0] grant_a [2];
    logic          cyc_a [2];
    logic          stb_a [2];
    logic          we_a [2];
    logic          to_a [2];
    logic [AW-1:0] adr_a [2];
    logic [DW-1:0] wdat_a [2];
    logic [DW-1:0] rdat_a [2];
    logic [SW-1:0] sel_a [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        wb_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .MODE(g), .TIMEOUT(TO)) u_dut (
            .clk(clk), .rst(rst),
            .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
            .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
            .m_ack_o(ack_a[g]), .m_err_o(err_a[g]), .m_stall_o(stall_a[g]),
            .m_dat_o(rdat_a[g]),
            .s_cyc_o(cyc_a[g]), .s_stb_o(stb_a[g]), .s_we_o(we_a[g]),
            .s_adr_o(adr_a[g]), .s_dat_o(wdat_a[g]), .s_sel_o(sel_a[g]),
            .s_ack_i(s_ack), .s_err_i(s_err), .s_stall_i(s_stall), .s_dat_i(s_dat),
            .grant_o(grant_a[g]), .timeout_o(to_a[g])
        );
    end

    typedef struct packed {
        logic [NM-1:0] grant;
        logic [NM-1:0] ack;
        logic [NM-1:0] err;
        logic [NM-1:0] stall;
        logic          cyc;
        logic          stb;
        logic          we;
        logic          to;
        logic [AW-1:0] adr;
        logic [DW-1:0] wdat;
        logic [DW-1:0] rdat;
        logic [SW-1:0] sel;
    } exp_t;

    exp_t sbq0[$];
    exp_t sbq1[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: owner index (-1 = idle), last owner, watchdog count
    int own [2];
    int lst [2];
    int wd  [2];
    logic [NM-1:0] pcyc;
    logic          pack, perr, prst;
    int            hold [NM];

    task automatic model_reset();
        for (int g = 0; g < 2; g++) begin
            own[g] = -1;
            lst[g] = NM - 1;
            wd[g]  = 0;
        end
    endtask

    function automatic int pick(int g, logic [NM-1:0] cand);
        if (g == 1) begin
            for (int i = 0; i < NM; i++) if (cand[i]) return i;
        end else begin
            for (int k = 1; k <= NM; k++) if (cand[(lst[g] + k) % NM]) return (lst[g] + k) % NM;
        end
        return -1;
    endfunction

    task automatic model_edge();
        logic [NM-1:0] cand;
        int w;
        for (int g = 0; g < 2; g++) begin
            if (own[g] < 0) begin
                w = pick(g, pcyc);
                own[g] = w;
                if (w >= 0) lst[g] = w;
                wd[g] = 0;
            end else if ((wd[g] == TO) || !pcyc[own[g]]) begin
                cand = pcyc;
                cand[own[g]] = 1'b0;
                w = pick(g, cand);
                own[g] = w;
                if (w >= 0) lst[g] = w;
                wd[g] = 0;
            end else if (pack || perr) begin
                wd[g] = 0;
            end else begin
                wd[g] = wd[g] + 1;
            end
        end
    endtask

    function automatic exp_t expect_out(int g);
        exp_t e;
        int   o;
        logic tmo;
        e       = '0;
        e.stall = '1;
        e.rdat  = s_dat;
        if (own[g] >= 0) begin
            o          = own[g];
            tmo        = (wd[g] == TO);
            e.grant[o] = 1'b1;
            e.to       = tmo;
            e.cyc      = m_cyc[o] && !tmo;
            e.stb      = m_stb[o] && !tmo;
            e.we       = m_we[o];
            e.adr      = m_adr[o*AW +: AW];
            e.wdat     = m_dat[o*DW +: DW];
            e.sel      = m_sel[o*SW +: SW];
            e.ack[o]   = s_ack;
            e.err[o]   = s_err || tmo;
            e.stall[o] = s_stall;
        end
        return e;
    endfunction

    task automatic cmp(input string name, input int g, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d t=%0t got=%0h expected=%0h", name, g, $time, got, exp);
        end
    endtask

    task automatic check(input int g, input exp_t e);
        cmp("grant",  g, 64'(grant_a[g]), 64'(e.grant));
        cmp("m_ack",  g, 64'(ack_a[g]),   64'(e.ack));
        cmp("m_err",  g, 64'(err_a[g]),   64'(e.err));
        cmp("m_stall",g, 64'(stall_a[g]), 64'(e.stall));
        cmp("s_cyc",  g, 64'(cyc_a[g]),   64'(e.cyc));
        cmp("s_stb",  g, 64'(stb_a[g]),   64'(e.stb));
        cmp("s_we",   g, 64'(we_a[g]),    64'(e.we));
        cmp("timeout",g, 64'(to_a[g]),    64'(e.to));
        cmp("s_adr",  g, 64'(adr_a[g]),   64'(e.adr));
        cmp("s_dat",  g, 64'(wdat_a[g]),  64'(e.wdat));
        cmp("s_sel",  g, 64'(sel_a[g]),   64'(e.sel));
        cmp("m_dat",  g, 64'(rdat_a[g]),  64'(e.rdat));
    endtask

    // Monitor: one expected entry per instance per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (sbq0.size() > 0) check(0, sbq0.pop_front());
        if (sbq1.size() > 0) check(1, sbq1.pop_front());
    end

    initial begin
        bit quiet;
        rst = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0;
        m_adr = '0; m_dat = '0; m_sel = '0;
        s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0; s_dat = '0;
        for (int i = 0; i < NM; i++) hold[i] = 0;
        model_reset();
        pcyc = '0; pack = 1'b0; perr = 1'b0; prst = 1'b1;

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            if (prst) model_reset();
            else model_edge();

            rst = (c < 2) || (c >= 1500 && c < 1502) || (c == 2600);
            for (int i = 0; i < NM; i++) begin
                if (hold[i] > 0) hold[i]--;
                else if ($urandom_range(0, 2) == 0) hold[i] = $urandom_range(1, 10);
                m_cyc[i] = (hold[i] > 0);
            end
            m_stb = NM'($urandom);
            m_we  = NM'($urandom);
            m_adr = NM*AW'({$urandom, $urandom});
            m_dat = NM*DW'({$urandom, $urandom});
            m_sel = NM*SW'($urandom);
            quiet   = (c >= 800 && c < 1000);
            s_ack   = !quiet && ($urandom_range(0, 2) == 0);
            s_err   = !quiet && ($urandom_range(0, 15) == 0);
            s_stall = ($urandom_range(0, 2) == 0);
            s_dat   = DW'($urandom);

            if (rst) model_reset();
            sbq0.push_back(expect_out(0));
            sbq1.push_back(expect_out(1));

            pcyc = m_cyc; pack = s_ack; perr = s_err; prst = rst;
        end

        @(negedge clk);
        #1;
        vectors++;
        if (sbq0.size() + sbq1.size() != 0) begin
            miscompares++;
            $display("FAIL drain got=%0d expected=0", sbq0.size() + sbq1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
